core_id_pipe_ctrl: RTL and testbench

//  Parametrised ID-stage pipeline register and hazard controller. It sits between IF and the EX-side decode/issue logic.

---
 rtl/core_id_pipe_ctrl_if.sv | 26 ++
 rtl/core_id_pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_core_id_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_id_pipe_ctrl_if.sv
// rtl/core_id_pipe_ctrl_if.sv - IF-side and EX-side handshake/payload bundle for the ID stage
interface core_id_pipe_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              valid_in;
  logic              ready_in;
  logic [PC_W-1:0]   i_pc;
  logic [INST_W-1:0] i_inst;
  logic              i_branch_pred;
  logic              valid_out;
  logic              ready_out;
  logic [PC_W-1:0]   o_pc;
  logic [INST_W-1:0] o_inst;
  logic              o_branch_pred;

  modport master (
    output valid_in, i_pc, i_inst, i_branch_pred, ready_out,
    input  ready_in, valid_out, o_pc, o_inst, o_branch_pred
  );

  modport slave (
    input  valid_in, i_pc, i_inst, i_branch_pred, ready_out,
    output ready_in, valid_out, o_pc, o_inst, o_branch_pred
  );
endinterface

// File: rtl/core_id_pipe_ctrl.sv
// rtl/core_id_pipe_ctrl.sv - ID-stage pipeline register with skid entry, RAW forwarding and hazard stall control
module core_id_pipe_ctrl #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int RFIDX_W = 5,
  parameter int NUM_FWD = 3,
  parameter int SKID    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  core_id_pipe_ctrl_if.slave         bus,
  input  logic                       dec_rs1_ren,
  input  logic                       dec_rs2_ren,
  input  logic [XLEN-1:0]            rs1_dat,
  input  logic [XLEN-1:0]            rs2_dat,
  input  logic [NUM_FWD*RFIDX_W-1:0] fwd_rd_idx,
  input  logic [NUM_FWD-1:0]         fwd_rd_wen,
  input  logic [NUM_FWD-1:0]         fwd_rd_rdy,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_dat,
  output logic [XLEN-1:0]            o_rs1_dat,
  output logic [XLEN-1:0]            o_rs2_dat,
  output logic [15:0]                o_stall_cnt
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  logic              pred_q;

  logic              skid_v;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              skid_pred;

  logic [RFIDX_W-1:0] rs1_idx;
  logic [RFIDX_W-1:0] rs2_idx;
  logic               haz1;
  logic               haz2;
  logic               hazard;
  logic               valid_out;
  logic               adv;
  logic               load;
  logic               ready_int;
  logic               accept;
  logic               in_to_main;
  logic               in_to_skid;

  assign rs1_idx = inst_q[15 +: RFIDX_W];
  assign rs2_idx = inst_q[20 +: RFIDX_W];

  // Operand select: scan oldest to youngest so the youngest matching producer wins
  always_comb begin
    o_rs1_dat = rs1_dat;
    o_rs2_dat = rs2_dat;
    haz1      = 1'b0;
    haz2      = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (dec_rs1_ren && (rs1_idx != '0) && fwd_rd_wen[k] &&
          (fwd_rd_idx[k*RFIDX_W +: RFIDX_W] == rs1_idx)) begin
        o_rs1_dat = fwd_dat[k*XLEN +: XLEN];
        haz1      = ~fwd_rd_rdy[k];
      end
      if (dec_rs2_ren && (rs2_idx != '0) && fwd_rd_wen[k] &&
          (fwd_rd_idx[k*RFIDX_W +: RFIDX_W] == rs2_idx)) begin
        o_rs2_dat = fwd_dat[k*XLEN +: XLEN];
        haz2      = ~fwd_rd_rdy[k];
      end
    end
  end

  assign hazard    = valid_q & (haz1 | haz2);
  assign valid_out = valid_q & ~hazard & ~flush;
  assign adv       = valid_out & bus.ready_out;
  assign load      = ~valid_q | adv;

  // With a skid entry, ready_in depends only on state; without it, it follows ready_out combinationally
  assign ready_int  = (SKID != 0) ? ~skid_v : (~valid_q | (bus.ready_out & ~hazard));
  assign accept     = bus.valid_in & ready_int & ~flush;
  assign in_to_main = accept & load & ~skid_v;
  assign in_to_skid = (SKID != 0) & accept & ~in_to_main;

  assign bus.ready_in      = ready_int;
  assign bus.valid_out     = valid_out;
  assign bus.o_pc          = pc_q;
  assign bus.o_inst        = inst_q;
  assign bus.o_branch_pred = pred_q;

  // Main register: skid entry has priority over new input to keep program order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      pred_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      if (skid_v) begin
        valid_q <= 1'b1;
        pc_q    <= skid_pc;
        inst_q  <= skid_inst;
        pred_q  <= skid_pred;
      end else if (in_to_main) begin
        valid_q <= 1'b1;
        pc_q    <= bus.i_pc;
        inst_q  <= bus.i_inst;
        pred_q  <= bus.i_branch_pred;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Skid entry: captures an accept that cannot go straight to main, empties when main takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v    <= 1'b0;
      skid_pc   <= '0;
      skid_inst <= '0;
      skid_pred <= 1'b0;
    end else if (flush) begin
      skid_v <= 1'b0;
    end else if (in_to_skid) begin
      skid_v    <= 1'b1;
      skid_pc   <= bus.i_pc;
      skid_inst <= bus.i_inst;
      skid_pred <= bus.i_branch_pred;
    end else if (skid_v && load) begin
      skid_v <= 1'b0;
    end
  end

  // Saturating count of cycles a held instruction waits on a pending producer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stall_cnt <= '0;
    end else if (hazard && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_core_id_pipe_ctrl.sv
// tb/tb_core_id_pipe_ctrl.sv - randomized scoreboard bench for core_id_pipe_ctrl
module tb_core_id_pipe_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dec_rs1_ren;
  logic        dec_rs2_ren;
  logic [31:0] rs1_dat;
  logic [31:0] rs2_dat;
  logic [14:0] fwd_rd_idx;
  logic [2:0]  fwd_rd_wen;
  logic [2:0]  fwd_rd_rdy;
  logic [95:0] fwd_dat;
  logic [31:0] o_rs1_dat;
  logic [31:0] o_rs2_dat;
  logic [15:0] o_stall_cnt;

  logic [4:0]  f_idx [3];
  logic        f_wen [3];
  logic        f_rdy [3];
  logic [31:0] f_dat [3];

  item_t       exp_q [$];
  int          occ_snap;
  logic [15:0] m_cnt;
  int          n_chk;
  int          n_err;

  core_id_pipe_ctrl_if #(.PC_W(32), .INST_W(32)) bus ();

  assign fwd_rd_idx = {f_idx[2], f_idx[1], f_idx[0]};
  assign fwd_rd_wen = {f_wen[2], f_wen[1], f_wen[0]};
  assign fwd_rd_rdy = {f_rdy[2], f_rdy[1], f_rdy[0]};
  assign fwd_dat    = {f_dat[2], f_dat[1], f_dat[0]};

  core_id_pipe_ctrl #(
    .XLEN(32), .PC_W(32), .INST_W(32), .RFIDX_W(5), .NUM_FWD(3), .SKID(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .dec_rs1_ren (dec_rs1_ren),
    .dec_rs2_ren (dec_rs2_ren),
    .rs1_dat     (rs1_dat),
    .rs2_dat     (rs2_dat),
    .fwd_rd_idx  (fwd_rd_idx),
    .fwd_rd_wen  (fwd_rd_wen),
    .fwd_rd_rdy  (fwd_rd_rdy),
    .fwd_dat     (fwd_dat),
    .o_rs1_dat   (o_rs1_dat),
    .o_rs2_dat   (o_rs2_dat),
    .o_stall_cnt (o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: first stage (youngest) writing a nonzero register that is read decides the operand
  function automatic void model_op(input logic ren, input logic [4:0] idx, input logic [31:0] rf,
                                   output logic [31:0] op, output logic haz);
    op  = rf;
    haz = 1'b0;
    if (ren && idx != 5'd0) begin
      for (int k = 0; k < 3; k++) begin
        if (f_wen[k] && f_idx[k] == idx) begin
          if (f_rdy[k]) op = f_dat[k];
          else          haz = 1'b1;
          break;
        end
      end
    end
  endfunction

  // Monitor: compares DUT against the queue model, pops on issue, then advances the model
  always @(negedge clk) begin
    logic [31:0] e1, e2;
    logic        h1, h2, e_vout;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt    = 16'd0;
      occ_snap = 0;
      chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
      chk("rst_ready_in", {31'd0, bus.ready_in}, 32'd1);
      chk("rst_stall_cnt", {16'd0, o_stall_cnt}, 32'd0);
    end else begin
      occ_snap = exp_q.size();
      e1 = rs1_dat;
      e2 = rs2_dat;
      h1 = 1'b0;
      h2 = 1'b0;
      if (occ_snap > 0) begin
        model_op(dec_rs1_ren, exp_q[0].inst[19:15], rs1_dat, e1, h1);
        model_op(dec_rs2_ren, exp_q[0].inst[24:20], rs2_dat, e2, h2);
      end
      e_vout = (occ_snap > 0) && !h1 && !h2 && !flush;
      chk("valid_out", {31'd0, bus.valid_out}, {31'd0, e_vout});
      chk("ready_in", {31'd0, bus.ready_in}, (occ_snap < 2) ? 32'd1 : 32'd0);
      chk("stall_cnt", {16'd0, o_stall_cnt}, {16'd0, m_cnt});
      if (occ_snap > 0 && (h1 || h2) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (flush) begin
        exp_q.delete();
      end else if (e_vout && bus.ready_out) begin
        chk("o_pc", bus.o_pc, exp_q[0].pc);
        chk("o_inst", bus.o_inst, exp_q[0].inst);
        chk("o_pred", {31'd0, bus.o_branch_pred}, {31'd0, exp_q[0].pred});
        chk("o_rs1_dat", o_rs1_dat, e1);
        chk("o_rs2_dat", o_rs2_dat, e2);
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle: record an accepted instruction in the scoreboard, then move past the next edge
  task automatic step();
    @(negedge clk);
    #2;
    if (rst_n && bus.valid_in && !flush && occ_snap < 2)
      exp_q.push_back('{pc: bus.i_pc, inst: bus.i_inst, pred: bus.i_branch_pred});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input int i);
    logic [31:0] inst;
    inst = $urandom;
    inst[19:15] = 5'($urandom_range(0, 7));
    inst[24:20] = 5'($urandom_range(0, 7));
    bus.valid_in      = ($urandom_range(0, 9) < 7);
    bus.ready_out     = ($urandom_range(0, 9) < 6);
    bus.i_pc          = 32'(i) << 2;
    bus.i_inst        = inst;
    bus.i_branch_pred = 1'($urandom_range(0, 1));
    flush             = ($urandom_range(0, 49) == 0);
    dec_rs1_ren       = ($urandom_range(0, 3) != 0);
    dec_rs2_ren       = ($urandom_range(0, 3) != 0);
    rs1_dat           = $urandom;
    rs2_dat           = $urandom;
    for (int k = 0; k < 3; k++) begin
      f_idx[k] = 5'($urandom_range(0, 7));
      f_wen[k] = ($urandom_range(0, 3) != 0);
      f_rdy[k] = ($urandom_range(0, 4) != 0);
      f_dat[k] = $urandom;
    end
  endtask

  initial begin
    logic [31:0] inst;
    n_chk = 0;
    n_err = 0;
    m_cnt = 16'd0;
    occ_snap = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b0;
    bus.i_pc = '0;
    bus.i_inst = '0;
    bus.i_branch_pred = 1'b0;
    dec_rs1_ren = 1'b0;
    dec_rs2_ren = 1'b0;
    rs1_dat = '0;
    rs2_dat = '0;
    for (int k = 0; k < 3; k++) begin
      f_idx[k] = '0;
      f_wen[k] = 1'b0;
      f_rdy[k] = 1'b1;
      f_dat[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
      rand_inputs(i);
      step();
    end

    flush = 1'b1;
    bus.valid_in = 1'b0;
    step();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f_wen[k] = 1'b0;
      f_rdy[k] = 1'b1;
    end
    f_idx[0] = 5'd3;
    f_wen[0] = 1'b1;
    f_rdy[0] = 1'b0;
    f_dat[0] = 32'h0000_0011;
    f_idx[2] = 5'd0;
    f_wen[2] = 1'b1;
    f_rdy[2] = 1'b0;
    dec_rs1_ren = 1'b1;
    dec_rs2_ren = 1'b1;
    inst = 32'h0;
    inst[19:15] = 5'd3;
    inst[24:20] = 5'd0;
    bus.valid_in = 1'b1;
    bus.ready_out = 1'b1;
    bus.i_pc = 32'h0000_1000;
    bus.i_inst = inst;
    bus.i_branch_pred = 1'b1;
    step();
    bus.valid_in = 1'b0;
    repeat (70000) step();
    chk("stall_saturated", {16'd0, o_stall_cnt}, 32'h0000_FFFF);
    f_rdy[0] = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
